// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 stream demultiplexer.
// Steers each accepted input word to channel A (in_sel=0) or channel B
// (in_sel=1). Each channel owns a DEPTH-entry FIFO, so a stalled consumer
// never blocks words already queued for the other consumer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_sel   producer handshake and destination select
//   in_data[N]                 producer word
//   a_valid/a_ready/a_data     channel A head word and consumer handshake
//   a_count                    channel A occupancy
//   b_valid/b_ready/b_data     channel B head word and consumer handshake
//   b_count                    channel B occupancy
module stream_demux2 #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sel,
  input  logic [N-1:0]                 in_data,
  output logic                         a_valid,
  input  logic                         a_ready,
  output logic [N-1:0]                 a_data,
  output logic [$clog2(DEPTH+1)-1:0]   a_count,
  output logic                         b_valid,
  input  logic                         b_ready,
  output logic [N-1:0]                 b_data,
  output logic [$clog2(DEPTH+1)-1:0]   b_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0][DEPTH-1:0][N-1:0] mem;
  logic [1:0][PW-1:0]           wr_ptr;
  logic [1:0][PW-1:0]           rd_ptr;
  logic [1:0][CW-1:0]           count;
  // Holds in_ready low during reset and until the first edge after release.
  logic                         run_q;

  logic [1:0] full_c;
  logic [1:0] vld_c;
  logic [1:0] push_c;
  logic [1:0] pop_c;
  logic [1:0] rdy_c;

  // Handshake decode; full/empty come from the counts, never the pointers.
  always_comb begin
    full_c   = '0;
    vld_c    = '0;
    for (int ch = 0; ch < 2; ch++) begin
      full_c[ch] = (count[ch] == FULL_COUNT);
      vld_c[ch]  = (count[ch] != '0);
    end
    in_ready  = run_q && (in_sel ? !full_c[1] : !full_c[0]);
    push_c    = '0;
    push_c[0] = in_valid && in_ready && !in_sel;
    push_c[1] = in_valid && in_ready && in_sel;
    rdy_c     = {b_ready, a_ready};
    pop_c     = vld_c & rdy_c;
  end

  // Per-channel FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        if (push_c[ch]) begin
          mem[ch][wr_ptr[ch]] <= in_data;
          wr_ptr[ch]          <= wr_ptr[ch] + PW'(1);
        end
        if (pop_c[ch]) begin
          rd_ptr[ch] <= rd_ptr[ch] + PW'(1);
        end
        if (push_c[ch] && !pop_c[ch]) begin
          count[ch] <= count[ch] + CW'(1);
        end else if (!push_c[ch] && pop_c[ch]) begin
          count[ch] <= count[ch] - CW'(1);
        end
      end
    end
  end

  // Heads are read straight from storage so they hold while stalled.
  always_comb begin
    a_valid = vld_c[0];
    a_data  = mem[0][rd_ptr[0]];
    a_count = count[0];
    b_valid = vld_c[1];
    b_data  = mem[1][rd_ptr[1]];
    b_count = count[1];
  end

endmodule
